mpack: RTL and testbench
========================

MPACK -- requirements
Module: mpack

Interface
REQ-001 Parameter N, default 8: FFT frame length in samples; SHALL be a power of two and at least 2.
REQ-002 Parameter WIDTH, default 32: width of a data sample.
REQ-003 Parameter MWIDTH, default 1: width of a metadata word.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_nd  input  1  new FFT output sample valid this cycle.
REQ-007 in_data  input  WIDTH  FFT output sample.
REQ-008 in_first  input  1  qualifies in_nd; marks the first sample of an FFT output frame.
REQ-009 in_m  input  MWIDTH  metadata from the metadata store; valid combinationally.
REQ-010 out_read  output  1  read strobe to the metadata store.
REQ-011 out_nd  output  1  paired sample valid.
REQ-012 out_data  output  WIDTH  paired sample data.
REQ-013 out_m  output  MWIDTH  metadata paired with out_data.
REQ-014 error  output  1  sticky framing error.

Function
REQ-015 out_read SHALL equal in_nd combinationally in every state, so the store advances once per FFT output sample.
REQ-016 A holding register m_hold SHALL load in_m on every clock, so it holds the entry for the current store address.
REQ-017 An accepted sample SHALL appear one cycle later: out_nd=1, out_data=in_data and out_m=m_hold, all registered.
REQ-018 out_nd SHALL be 0 in any cycle that follows a cycle with no accepted sample; out_data and out_m SHALL then hold their previous values.
REQ-019 Two states: SYNC (the reset state) and STREAM.
REQ-020 SYNC: in_nd with in_first=1 SHALL be accepted; count becomes 1 and the state becomes STREAM.
REQ-021 SYNC: in_nd with in_first=0 SHALL be dropped (no out_nd) and SHALL set error.
REQ-022 STREAM: every in_nd SHALL be accepted and count SHALL increment; at count=N-1 it wraps to 0 and the state stays STREAM.
REQ-023 STREAM: in_first=1 when count!=0 SHALL set error, reset count to 1, and accept the sample as the start of a new frame.
REQ-024 STREAM: in_first=0 when count=0 SHALL set error and the state SHALL return to SYNC; that sample SHALL be dropped.
REQ-025 count SHALL be clog2(N) bits wide with modulo-N wrap.
REQ-026 error SHALL be sticky until reset.
REQ-027 in_first SHALL be ignored when in_nd=0.
REQ-028 The system SHALL guarantee at least 2 cycles between the store's final fill write and the first in_nd of a frame; mpack does not check this.

Reset
REQ-029 While rst=1: state=SYNC, count=0, out_nd=0, out_data=0, out_m=0, m_hold=0, error=0.
REQ-030 A rst asserted mid-frame SHALL abort the frame with no further out_nd; the next frame SHALL begin only on an in_first.

Configuration
REQ-031 Macro MPACK_FRAME_MARK_EN defined: outputs out_first and out_last (1 bit each) SHALL exist, registered alongside out_nd.
REQ-032 With MPACK_FRAME_MARK_EN: out_first=1 for the output of count 0; out_last=1 for the output of count N-1; both reset to 0.
REQ-033 Without MPACK_FRAME_MARK_EN: these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 The clog2 function and the SYNC/STREAM state encoding SHALL reside in the shared fft package.
REQ-035 The modulo-N sample counter SHALL be a sub-module, frame_counter (inputs: inc, restart; outputs: count, wrap), reusable by other fft stages.

Verification
REQ-036 N=8; 8 back-to-back in_nd with in_first on the first, in_m entries 0..7 -> 8 out_nd with out_m=0..7 in order, 1-cycle latency, error=0.
REQ-037 SYNC; in_nd with in_first=0 -> no out_nd, out_read=1, error=1.
REQ-038 in_first at count=5 -> error=1; the following 8 outputs form a new frame (out_first on the first of them when MPACK_FRAME_MARK_EN is defined).
REQ-039 Gapped input: in_nd every third cycle for 8 samples -> out_m ordering intact, out_nd pulses exactly 8, last pulse has out_last=1.
REQ-040 rst pulse after 3 samples of a frame -> all outputs 0 immediately; a later in_nd without in_first is dropped with error=1.

Source files
------------

// File: rtl/mpack_pkg.sv
// mpack_pkg -- definitions shared by the fft output stages.
//   state_t : SYNC/STREAM encoding of the frame-alignment FSM
//   clog2   : ceiling log2, used to size frame counters
// Optional feature macro used by the block: MPACK_FRAME_MARK_EN
package mpack_pkg;

    typedef enum logic {
        SYNC   = 1'b0,   // waiting for a sample flagged in_first
        STREAM = 1'b1    // locked to the frame, counting samples
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mpack_if.sv
// mpack_if -- FFT output / metadata store / paired output bundle.
//   master : the FFT + metadata store side (drives in_*, sees out_*)
//   slave  : mpack itself
// With MPACK_FRAME_MARK_EN defined, out_first/out_last are added.
interface mpack_if #(
    parameter int WIDTH  = 32,
    parameter int MWIDTH = 1
);
    logic              in_nd;
    logic              in_first;
    logic [WIDTH-1:0]  in_data;
    logic [MWIDTH-1:0] in_m;
    logic              out_read;
    logic              out_nd;
    logic [WIDTH-1:0]  out_data;
    logic [MWIDTH-1:0] out_m;
    logic              error;
`ifdef MPACK_FRAME_MARK_EN
    logic              out_first;
    logic              out_last;

    modport master (
        output in_nd, in_first, in_data, in_m,
        input  out_read, out_nd, out_data, out_m, error, out_first, out_last
    );
    modport slave (
        input  in_nd, in_first, in_data, in_m,
        output out_read, out_nd, out_data, out_m, error, out_first, out_last
    );
`else
    modport master (
        output in_nd, in_first, in_data, in_m,
        input  out_read, out_nd, out_data, out_m, error
    );
    modport slave (
        input  in_nd, in_first, in_data, in_m,
        output out_read, out_nd, out_data, out_m, error
    );
`endif
endinterface

// File: rtl/mpack_frame_counter.sv
// frame_counter -- modulo-N sample counter for fft frame tracking.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : advance count by one (wraps N-1 -> 0)
//   restart  : current sample is index 0, so count becomes 1 (wins over inc)
//   count    : index of the next expected sample, clog2(N) bits
//   wrap     : combinational, inc while count == N-1
module frame_counter
    import mpack_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                restart,
    output logic [clog2(N)-1:0] count,
    output logic                wrap
);
    localparam int CW = clog2(N);

    logic [CW-1:0] r_count;

    assign count = r_count;
    assign wrap  = inc && (r_count == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_count <= '0;
        else if (restart) r_count <= CW'(1);
        else if (inc)     r_count <= wrap ? '0 : r_count + CW'(1);
    end
endmodule

// File: rtl/mpack.sv
// mpack -- pairs each FFT output sample with its metadata-store entry,
// checks frame alignment and flags framing errors.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mpack_if.slave
//     in_nd/in_data/in_first : FFT output sample stream
//     in_m / out_read        : metadata store entry and its read strobe
//     out_nd/out_data/out_m  : registered paired output, 1-cycle latency
//     error                  : sticky framing error
//     out_first/out_last     : frame marks, only with MPACK_FRAME_MARK_EN
// Parameters: N (power of two, >= 2), WIDTH, MWIDTH.
module mpack
    import mpack_pkg::*;
#(
    parameter int N      = 8,
    parameter int WIDTH  = 32,
    parameter int MWIDTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    mpack_if.slave bus
);
    localparam int CW = clog2(N);

    state_t            r_state, w_nxt;
    logic [CW-1:0]     w_count;
    logic              w_accept, w_restart, w_inc, w_err_set, w_is_first;
    logic [MWIDTH-1:0] r_m_hold;
    logic              r_out_nd, r_error;
    logic [WIDTH-1:0]  r_out_data;
    logic [MWIDTH-1:0] r_out_m;

    // The store advances on every FFT sample, accepted or dropped.
    assign bus.out_read = bus.in_nd;
    assign bus.out_nd   = r_out_nd;
    assign bus.out_data = r_out_data;
    assign bus.out_m    = r_out_m;
    assign bus.error    = r_error;

`ifdef MPACK_FRAME_MARK_EN
    logic w_wrap, r_out_first, r_out_last;
    assign bus.out_first = r_out_first;
    assign bus.out_last  = r_out_last;
`endif

    frame_counter #(.N(N)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_inc),
        .restart (w_restart),
        .count   (w_count),
`ifdef MPACK_FRAME_MARK_EN
        .wrap    (w_wrap)
`else
        .wrap    ()
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= SYNC;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt      = r_state;
        w_accept   = 1'b0;
        w_restart  = 1'b0;
        w_inc      = 1'b0;
        w_err_set  = 1'b0;
        w_is_first = 1'b0;
        if (bus.in_nd) begin
            unique case (r_state)
                SYNC: begin
                    if (bus.in_first) begin
                        w_accept   = 1'b1;
                        w_restart  = 1'b1;
                        w_is_first = 1'b1;
                        w_nxt      = STREAM;
                    end else begin
                        w_err_set  = 1'b1;
                    end
                end
                STREAM: begin
                    if (bus.in_first) begin
                        // A new frame always resynchronises; it is only an
                        // error if the previous frame was cut short.
                        w_accept   = 1'b1;
                        w_restart  = 1'b1;
                        w_is_first = 1'b1;
                        w_err_set  = (w_count != '0);
                    end else if (w_count == '0) begin
                        // Frame boundary without in_first: lost alignment.
                        w_err_set  = 1'b1;
                        w_nxt      = SYNC;
                    end else begin
                        w_accept   = 1'b1;
                        w_inc      = 1'b1;
                    end
                end
                default: w_nxt = SYNC;
            endcase
        end
    end

    // m_hold tracks the store's current entry every cycle; the store presents
    // the entry for the next sample by the cycle before that sample arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_hold   <= '0;
            r_out_nd   <= 1'b0;
            r_out_data <= '0;
            r_out_m    <= '0;
            r_error    <= 1'b0;
        end else begin
            r_m_hold <= bus.in_m;
            r_out_nd <= w_accept;
            if (w_accept) begin
                r_out_data <= bus.in_data;
                r_out_m    <= r_m_hold;
            end
            if (w_err_set) r_error <= 1'b1;
        end
    end

`ifdef MPACK_FRAME_MARK_EN
    // Index 0 is only reachable through in_first; index N-1 only through a
    // counter wrap, so the marks fall straight out of the FSM/counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_first <= w_is_first;
            r_out_last  <= w_wrap;
        end
    end
`endif
endmodule

// File: tb/tb_mpack.sv
module tb_mpack;
    localparam int N  = 8;
    localparam int W  = 32;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpack_if #(.WIDTH(W), .MWIDTH(MW)) bus ();

    mpack #(.N(N), .WIDTH(W), .MWIDTH(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [W-1:0]  d;
        logic [MW-1:0] m;
        logic          f;
        logic          l;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_pulse = 0;

    // Metadata store model: entry at address a is 8'h40 | a; the entry shown
    // is the one for the next sample to be read.
    logic [2:0] ptr    = 3'd0;
    logic       st_clr = 1'b0;
    always @(posedge clk) begin
        if (st_clr)            ptr <= 3'd0;
        else if (bus.out_read) ptr <= ptr + 3'd1;
    end
    always_comb bus.in_m = {5'b01000, 3'(ptr + {2'b00, bus.out_read})};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every out_nd pops one expected pairing.
    always @(negedge clk) begin
        exp_t e;
        if (bus.out_nd === 1'b1) begin
            n_pulse++;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_nd: got data %0h m %0h expected no output",
                         bus.out_data, bus.out_m);
            end else begin
                e = q.pop_front();
                check("out_data", 64'(bus.out_data), 64'(e.d));
                check("out_m", 64'(bus.out_m), 64'(e.m));
`ifdef MPACK_FRAME_MARK_EN
                check("out_first", 64'(bus.out_first), 64'(e.f));
                check("out_last", 64'(bus.out_last), 64'(e.l));
`endif
            end
        end
    end

    task automatic send(input logic first, input logic [W-1:0] d, input logic acc,
                        input logic [MW-1:0] m, input logic f, input logic l);
        exp_t e;
        @(posedge clk); #1;
        bus.in_nd    = 1'b1;
        bus.in_first = first;
        bus.in_data  = d;
        #1;
        check("out_read", 64'(bus.out_read), 64'd1);
        if (acc) begin
            e.d = d; e.m = m; e.f = f; e.l = l;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.in_nd    = 1'b0;
            bus.in_first = 1'b0;
        end
    endtask

    task automatic sclr();
        @(posedge clk); #1;
        bus.in_nd = 1'b0; bus.in_first = 1'b0; st_clr = 1'b1;
        @(posedge clk); #1;
        st_clr = 1'b0;
    endtask

    task automatic rst_pulse();
        @(posedge clk); #1;
        bus.in_nd = 1'b0; bus.in_first = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int p0;
        bus.in_nd = 1'b0; bus.in_first = 1'b0; bus.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        check("rst_out_nd", 64'(bus.out_nd), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_m", 64'(bus.out_m), 64'd0);
        check("rst_error", 64'(bus.error), 64'd0);
        check("rst_out_read", 64'(bus.out_read), 64'd0);
`ifdef MPACK_FRAME_MARK_EN
        check("rst_out_first", 64'(bus.out_first), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
`endif
        rst = 1'b0;

        // full back-to-back frame
        sclr();
        p0 = n_pulse;
        for (int k = 0; k < 8; k++)
            send(k == 0, 32'hA000_0000 + k, 1'b1, 8'h40 + 8'(k), k == 0, k == 7);
        idle(2);
        check("frame_pulses", 64'(n_pulse - p0), 64'd8);
        check("frame_error", 64'(bus.error), 64'd0);

        // SYNC, sample without in_first is dropped
        rst_pulse();
        sclr();
        p0 = n_pulse;
        send(1'b0, 32'h0000_BAD0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        check("drop_pulses", 64'(n_pulse - p0), 64'd0);
        check("drop_error", 64'(bus.error), 64'd1);

        // in_first at count 5 restarts the frame
        rst_pulse();
        sclr();
        for (int k = 0; k < 5; k++)
            send(k == 0, 32'hC000_0000 + k, 1'b1, 8'h40 + 8'(k), k == 0, 1'b0);
        idle(1);
        check("early_error_clear", 64'(bus.error), 64'd0);
        for (int k = 0; k < 8; k++)
            send(k == 0, 32'hD000_0000 + k, 1'b1, 8'h40 + 8'((5 + k) % 8), k == 0, k == 7);
        idle(2);
        check("restart_error", 64'(bus.error), 64'd1);

        // gapped input: one sample every third cycle
        rst_pulse();
        sclr();
        p0 = n_pulse;
        for (int k = 0; k < 8; k++) begin
            send(k == 0, 32'hE000_0000 + k, 1'b1, 8'h40 + 8'(k), k == 0, k == 7);
            idle(2);
        end
        check("gap_pulses", 64'(n_pulse - p0), 64'd8);
        check("gap_error", 64'(bus.error), 64'd0);

        // reset mid-frame
        rst_pulse();
        sclr();
        for (int k = 0; k < 3; k++)
            send(k == 0, 32'hF000_0000 + k, 1'b1, 8'h40 + 8'(k), k == 0, 1'b0);
        @(posedge clk); #1;
        bus.in_nd = 1'b0; bus.in_first = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_nd", 64'(bus.out_nd), 64'd0);
        check("midrst_out_data", 64'(bus.out_data), 64'd0);
        check("midrst_out_m", 64'(bus.out_m), 64'd0);
        check("midrst_error", 64'(bus.error), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_queue", 64'(q.size()), 64'd0);
        sclr();
        p0 = n_pulse;
        send(1'b0, 32'hF0FF_0000, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        check("postrst_pulses", 64'(n_pulse - p0), 64'd0);
        check("postrst_error", 64'(bus.error), 64'd1);

        idle(3);
        check("final_queue", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
